rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. a priority-encoder datapath or a shared bus port) among REQ_N requesters.
- Uses a rotating-pointer mask in front of a lowest-set-bit priority encoder, giving starvation-free, registered one-hot grants.
- An optional hold limit forces release after a maximum grant length, so one requester cannot monopolise the resource.

---
 rtl/rr_arbiter_pkg.sv | 22 ++
 rtl/pe_lsb_onehot.sv | 26 ++
 rtl/rr_arbiter.sv | 115 +++++++++++
 tb/tb_rr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared types and helpers for the round-robin arbiter
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int MAX_REQ_N = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bits at or above ptr survive; callers cast down to their own width.
   function automatic logic [MAX_REQ_N-1:0] rot_mask(input int ptr);
      logic [MAX_REQ_N-1:0] m;
      m = {MAX_REQ_N{1'b1}} << ptr;
      return m;
   endfunction

endpackage

// File: rtl/pe_lsb_onehot.sv
// rtl/pe_lsb_onehot.sv - lowest-set-bit priority encoder with one-hot, index and any outputs
module pe_lsb_onehot #(
   parameter int W  = 4,
   parameter int IW = 2
) (
   input  logic [W-1:0]  i_vec,
   output logic [W-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [W-1:0] w_oh;

   // Two's-complement trick isolates the lowest set bit.
   assign w_oh     = i_vec & (~i_vec + W'(1));
   assign o_onehot = w_oh;
   assign o_any    = |i_vec;

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < W; i++) begin
         if (w_oh[i]) o_idx = IW'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating-pointer mask and optional hold limit
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int REQ_N    = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk_150mhz_i,
   input  logic                     srst_i,
   input  logic [REQ_N-1:0]         req_i,
   output logic [REQ_N-1:0]         gnt_o,
   output logic [$clog2(REQ_N)-1:0] gnt_idx_o,
   output logic                     gnt_val_o
);

   localparam int IW = idx_w(REQ_N);
   localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

   arb_state_t      r_state, w_state_nxt;
   logic [REQ_N-1:0] r_gnt, w_gnt_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic             r_val, w_val_nxt;
   logic [IW-1:0]    r_ptr, w_ptr_nxt;
   logic [HW-1:0]    r_hold, w_hold_nxt;

   logic [IW-1:0]    w_rel_ptr, w_sel_ptr;
   logic [REQ_N-1:0] w_mask, w_m_oh, w_u_oh, w_sel_oh;
   logic [IW-1:0]    w_m_idx, w_u_idx, w_sel_idx;
   logic             w_m_any, w_u_any, w_keep;

   // A release evaluates with the pointer just past the current holder.
   assign w_rel_ptr = (r_idx == IW'(REQ_N - 1)) ? '0 : r_idx + IW'(1);
   assign w_sel_ptr = (r_state == GRANT) ? w_rel_ptr : r_ptr;
   assign w_mask    = REQ_N'(rot_mask(int'(w_sel_ptr)));

   pe_lsb_onehot #(.W(REQ_N), .IW(IW)) u_pe_masked (
      .i_vec    (req_i & w_mask),
      .o_onehot (w_m_oh),
      .o_idx    (w_m_idx),
      .o_any    (w_m_any)
   );

   pe_lsb_onehot #(.W(REQ_N), .IW(IW)) u_pe_raw (
      .i_vec    (req_i),
      .o_onehot (w_u_oh),
      .o_idx    (w_u_idx),
      .o_any    (w_u_any)
   );

   assign w_sel_oh  = w_m_any ? w_m_oh  : w_u_oh;
   assign w_sel_idx = w_m_any ? w_m_idx : w_u_idx;
   assign w_keep    = req_i[r_idx] && ((MAX_HOLD == 0) || (r_hold < HW'(MAX_HOLD)));

   always_ff @(posedge clk_150mhz_i) begin
      if (srst_i) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_val   <= 1'b0;
         r_ptr   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idx   <= w_idx_nxt;
         r_val   <= w_val_nxt;
         r_ptr   <= w_ptr_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_idx;
      w_val_nxt   = r_val;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold;
      case (r_state)
         IDLE: begin
            if (w_u_any) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = w_sel_oh;
               w_idx_nxt   = w_sel_idx;
               w_val_nxt   = 1'b1;
               w_hold_nxt  = HW'(1);
            end
         end
         GRANT: begin
            if (w_keep) begin
               w_hold_nxt = (MAX_HOLD == 0) ? r_hold : r_hold + HW'(1);
            end else begin
               w_ptr_nxt = w_rel_ptr;
               if (w_u_any) begin
                  w_gnt_nxt  = w_sel_oh;
                  w_idx_nxt  = w_sel_idx;
                  w_hold_nxt = HW'(1);
               end else begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_val_nxt   = 1'b0;
                  w_hold_nxt  = '0;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign gnt_o     = r_gnt;
   assign gnt_idx_o = r_idx;
   assign gnt_val_o = r_val;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter (vector table plus randomized reference model)
module tb_rr_arbiter;

   localparam int N  = 4;
   localparam int MH = 4;

   logic         clk  = 1'b0;
   logic         srst = 1'b1;
   logic [N-1:0] req  = '0;
   logic [N-1:0] gnt;
   logic [1:0]   gidx;
   logic         gval;

   rr_arbiter #(.REQ_N(N), .MAX_HOLD(MH)) dut (
      .clk_150mhz_i (clk),
      .srst_i       (srst),
      .req_i        (req),
      .gnt_o        (gnt),
      .gnt_idx_o    (gidx),
      .gnt_val_o    (gval)
   );

   always #3 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] gnt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference state: granted index (-1 = none), tenure length, rotation start.
   int m_g   = -1;
   int m_cnt = 0;
   int m_ptr = 0;

   function automatic void add(input logic rst, input logic [N-1:0] r, input logic [N-1:0] g);
      vec_t v;
      v.rst = rst;
      v.req = r;
      v.gnt = g;
      vecs.push_back(v);
   endfunction

   function automatic int model_sel(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int oh2idx(input logic [N-1:0] g);
      for (int k = 0; k < N; k++) begin
         if (g[k]) return k;
      end
      return 0;
   endfunction

   task automatic model_step(input logic rst, input logic [N-1:0] r);
      int s;
      if (rst) begin
         m_g = -1; m_cnt = 0; m_ptr = 0;
      end else if (m_g < 0) begin
         s = model_sel(r, m_ptr);
         if (s >= 0) begin
            m_g = s; m_cnt = 1;
         end
      end else if (r[m_g] && m_cnt < MH) begin
         m_cnt = m_cnt + 1;
      end else begin
         m_ptr = (m_g + 1) % N;
         s = model_sel(r, m_ptr);
         m_g = s;
         m_cnt = (s >= 0) ? 1 : 0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic rst, input logic [N-1:0] r);
      int exp_gnt;
      srst = rst;
      req  = r;
      @(posedge clk);
      #1;
      model_step(rst, r);
      exp_gnt = (m_g >= 0) ? (1 << m_g) : 0;
      chk("model_gnt", int'(gnt), exp_gnt);
      chk("model_val", int'(gval), int'(m_g >= 0));
      chk("model_idx", int'(gidx), (m_g >= 0) ? m_g : 0);
      chk("inv_onehot", int'($onehot0(gnt)), 1);
      chk("inv_val", int'(gval), int'(gnt != '0));
      if (gval) chk("inv_idx_bit", int'(gnt[gidx]), 1);
   endtask

   initial begin
      logic [N-1:0] cur_req;
      logic         rst_r;

      // reset held with all requests up, then first grant
      for (int i = 0; i < 3; i++) add(1'b1, 4'b1111, 4'b0000);
      add(1'b0, 4'b1111, 4'b0001);
      // basic handoff with no idle gap
      add(1'b1, 4'b0000, 4'b0000);
      add(1'b0, 4'b0101, 4'b0001);
      add(1'b0, 4'b0100, 4'b0100);
      // fairness with hold-limit timeouts
      add(1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 20; i++) add(1'b0, 4'b1111, 4'(1 << ((i / MH) % N)));
      // wrap-around after release of index 2
      add(1'b1, 4'b0000, 4'b0000);
      add(1'b0, 4'b0100, 4'b0100);
      add(1'b0, 4'b0011, 4'b0001);
      // sole requester survives its own timeouts
      add(1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 10; i++) add(1'b0, 4'b0010, 4'b0010);
      add(1'b0, 4'b0000, 4'b0000);
      add(1'b0, 4'b0000, 4'b0000);
      // reset in the middle of a tenure restarts the rotation at 0
      add(1'b1, 4'b0000, 4'b0000);
      add(1'b0, 4'b1000, 4'b1000);
      add(1'b0, 4'b1000, 4'b1000);
      add(1'b1, 4'b1111, 4'b0000);
      add(1'b0, 4'b1111, 4'b0001);

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].req);
         chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(vecs[i].gnt));
         chk($sformatf("vec%0d_val", i), int'(gval), int'(vecs[i].gnt != '0));
         chk($sformatf("vec%0d_idx", i), int'(gidx), oh2idx(vecs[i].gnt));
      end

      cycle(1'b1, '0);
      cur_req = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) cur_req = N'($urandom_range(0, (1 << N) - 1));
         rst_r = ($urandom_range(0, 99) == 0);
         cycle(rst_r, cur_req);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
